// File: rtl/fxp_pkg.sv
// Shared sign-magnitude fixed-point constants and the reciprocal sequencer state type.
package fxp_pkg;

  localparam int N = 32;
  localparam int Q = 16;

  localparam logic [N-1:0] FXP_ONE     = {{(N-Q-1){1'b0}}, 1'b1, {Q{1'b0}}};
  localparam logic [N-1:0] FXP_TWO     = {{(N-Q-2){1'b0}}, 1'b1, {(Q+1){1'b0}}};
  localparam logic [N-1:0] FXP_MAX_MAG = {1'b0, {(N-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    STEP_A = 3'd2,
    STEP_B = 3'd3,
    DONE   = 3'd4
  } recip_state_t;

endpackage

// File: rtl/recip_nr_sequencer_if.sv
// Operand/result handshake bundle for the reciprocal sequencer; slave side is the unit itself.
interface recip_nr_sequencer_if;

  logic                   in_valid;
  logic                   in_ready;
  logic [fxp_pkg::N-1:0]  a;
  logic                   out_valid;
  logic                   out_ready;
  logic [fxp_pkg::N-1:0]  result;
  logic                   div_by_zero;
  logic                   busy;

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, result, div_by_zero, busy
  );

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, result, div_by_zero, busy
  );

endinterface

// File: rtl/add.sv
// Sign-magnitude add; like signs add (wrapping), unlike signs subtract and take the larger sign.
module add #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_s
);

  logic [N-2:0] w_mag;
  logic         w_sign;

  always_comb begin
    w_mag  = '0;
    w_sign = 1'b0;
    if (i_a[N-1] == i_b[N-1]) begin
      w_mag  = i_a[N-2:0] + i_b[N-2:0];
      w_sign = i_a[N-1];
    end else if (i_a[N-2:0] >= i_b[N-2:0]) begin
      w_mag  = i_a[N-2:0] - i_b[N-2:0];
      w_sign = i_a[N-1];
    end else begin
      w_mag  = i_b[N-2:0] - i_a[N-2:0];
      w_sign = i_b[N-1];
    end
    // A zero magnitude is always reported as positive zero.
    if (w_mag == '0) begin
      w_sign = 1'b0;
    end
  end

  assign o_s = {w_sign, w_mag};

endmodule

// File: rtl/mult.sv
// Sign-magnitude Q-format multiply; product magnitude is truncated and wraps on overflow.
module mult #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_p
);

  logic [2*N-3:0] w_full;
  logic           w_unused;

  assign w_full   = i_a[N-2:0] * i_b[N-2:0];
  assign o_p      = {i_a[N-1] ^ i_b[N-1], w_full[Q +: N-1]};
  assign w_unused = ^{w_full[2*N-3:Q+N-1], w_full[Q-1:0]};

endmodule

// File: rtl/recip_seed.sv
// Newton-Raphson seed: power-of-two estimate of 1/|a| so that |a|*seed lands in [0.5,1).
module recip_seed #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic [N-1:0] i_a,
  output logic [N-1:0] o_seed,
  output logic         o_is_zero
);

  localparam int           PW      = $clog2(N);
  localparam logic [N-2:0] MAG_ONE = {{(N-2){1'b0}}, 1'b1};

  logic [PW-1:0] w_p;
  int            w_sh;
  logic [N-2:0]  w_mag;

  always_comb begin
    w_p = '0;
    for (int i = 0; i < N-1; i++) begin
      if (i_a[i]) begin
        w_p = PW'(i);
      end
    end
  end

  always_comb begin
    w_sh = 2*Q - int'(w_p) - 1;
    if (w_sh > N-2) begin
      w_sh = N-2;
    end
    if (w_sh < 0) begin
      w_sh = 0;
    end
    w_mag = MAG_ONE << w_sh;
  end

  assign o_is_zero = ~|i_a[N-2:0];
  assign o_seed    = {i_a[N-1], w_mag};

endmodule

// File: rtl/recip_nr_sequencer.sv
// Iterative NR reciprocal sharing one mult and one add; result valid 2+2*ITER cycles after accept, held until out_ready.
// RECIP_EARLY_EXIT_EN finishes as soon as an iteration leaves x unchanged.
module recip_nr_sequencer
  import fxp_pkg::*;
#(
  parameter int ITER = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  recip_nr_sequencer_if.slave   bus
);

  recip_state_t r_state;
  recip_state_t w_next;

  logic [N-1:0] r_a;
  logic [N-1:0] r_x;
  logic [N-1:0] r_t;
  logic [N-1:0] r_result;
  logic         r_dbz;
  logic [3:0]   r_cnt;

  logic [N-1:0] w_mul_a;
  logic [N-1:0] w_mul_b;
  logic [N-1:0] w_mul_p;
  logic [N-1:0] w_add_a;
  logic [N-1:0] w_add_b;
  logic [N-1:0] w_add_s;
  logic [N-1:0] w_seed;
  logic         w_is_zero;
  logic [3:0]   w_cnt_nxt;
  logic         w_last;
  logic         w_finish;

  recip_seed #(.N(N), .Q(Q)) u_seed (
    .i_a       (r_a),
    .o_seed    (w_seed),
    .o_is_zero (w_is_zero)
  );

  mult #(.N(N), .Q(Q)) u_mult (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  add #(.N(N)) u_add (
    .i_a (w_add_a),
    .i_b (w_add_b),
    .o_s (w_add_s)
  );

  assign w_cnt_nxt = r_cnt + 4'd1;
  assign w_last    = (w_cnt_nxt == 4'(ITER));

`ifdef RECIP_EARLY_EXIT_EN
  assign w_finish = w_last || (w_mul_p == r_x);
`else
  assign w_finish = w_last;
`endif

  // Operands stay at zero outside the two arithmetic states so the multiplier does not toggle.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      STEP_A: begin
        w_mul_a = {~r_a[N-1], r_a[N-2:0]};
        w_mul_b = r_x;
        w_add_a = FXP_TWO;
        w_add_b = w_mul_p;
      end
      STEP_B: begin
        w_mul_a = r_x;
        w_mul_b = r_t;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = SEED;
      SEED:    w_next = w_is_zero ? DONE : STEP_A;
      STEP_A:  w_next = STEP_B;
      STEP_B:  w_next = w_finish ? DONE : STEP_A;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_x      <= '0;
      r_t      <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a <= bus.a;
          end
        end
        SEED: begin
          r_x   <= w_seed;
          r_cnt <= '0;
          r_dbz <= w_is_zero;
          if (w_is_zero) begin
            r_result <= {r_a[N-1], FXP_MAX_MAG[N-2:0]};
          end
        end
        STEP_A: begin
          r_t <= w_add_s;
        end
        STEP_B: begin
          r_x   <= w_mul_p;
          r_cnt <= w_cnt_nxt;
          if (w_finish) begin
            r_result <= w_mul_p;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_recip_nr_sequencer.sv
// Directed bench for recip_nr_sequencer: vector table plus backpressure and mid-operation reset sequences.
module tb_recip_nr_sequencer;
  import fxp_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp_res;
    logic        exp_dbz;
    int          exp_lat;
    int          tol;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  recip_nr_sequencer_if bus();

  recip_nr_sequencer #(.ITER(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    int diff;
    n_total++;
    diff = int'(act[30:0]) - int'(exp[30:0]);
    if (diff < 0) diff = -diff;
    if ($isunknown(act) || act[31] !== exp[31] || diff > tol)
      $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", name, act, exp, tol);
    else
      n_pass++;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp}, 0);
  endtask

  task automatic check_lat(input string name, input int act, input int exp);
    logic ok;
    n_total++;
`ifdef RECIP_EARLY_EXIT_EN
    ok = (act <= exp) && (act >= 2);
`else
    ok = (act == exp);
`endif
    if (!ok) $display("FAIL %s: latency %0d cycles, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Called at a negedge; returns latency in cycles counting the accept cycle as cycle 0.
  task automatic run_op(input logic [31:0] a, output logic [31:0] res, output logic dbz, output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); @(negedge clk); w++;
    end
    bus.a = a;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    res = bus.result;
    dbz = bus.div_by_zero;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] res;
    logic        dbz;
    int          lat;
    int          n;
    int          seen;

    vecs[0] = '{32'h0002_0000, 32'h0000_8000, 1'b0, 12, 1};
    vecs[1] = '{32'h8004_0000, 32'h8000_4000, 1'b0, 12, 1};
    vecs[2] = '{32'h0000_0000, 32'h7FFF_FFFF, 1'b1,  2, 0};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,  2, 0};
    vecs[4] = '{FXP_ONE,       FXP_ONE,       1'b0, 12, 1};
    vecs[5] = '{32'h0000_8000, FXP_TWO,       1'b0, 12, 1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;

    #1 reset = 1'b1;
    #2;
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, 32'h0, 0);
    check_bit("rst_dbz", bus.div_by_zero, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, res, dbz, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res, vecs[i].tol);
      check_bit($sformatf("vec%0d_dbz", i), dbz, vecs[i].exp_dbz);
      check_lat($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Backpressure: hold out_ready low while pulsing in_valid, which must be ignored.
    bus.a = FXP_ONE;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      bus.in_valid = n[0];
      bus.a = 32'h0004_0000;
      if (n == 4 || n == 9) check_bit("bp_busy_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); @(negedge clk);
      n++;
    end
    check_lat("bp_lat", n, 12);
    for (int c = 0; c < 5; c++) begin
      check_bit("bp_hold_valid", bus.out_valid, 1'b1);
      check_bit("bp_hold_in_ready", bus.in_ready, 1'b0);
      check("bp_hold_result", bus.result, FXP_ONE, 1);
      bus.in_valid = (c % 2 == 0) && (c != 4);
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    check_bit("bp_in_ready_after", bus.in_ready, 1'b1);
    check_bit("bp_out_valid_after", bus.out_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_bit("bp_no_queued_op", bus.busy, 1'b0);

    // Reset during STEP_A of the third iteration.
    bus.a = FXP_TWO;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
    end
    check_bit("mid_busy", bus.busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_bit("mid_rst_in_ready", bus.in_ready, 1'b1);
    check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_result", bus.result, 32'h0, 0);
    check_bit("mid_rst_dbz", bus.div_by_zero, 1'b0);
    check_bit("mid_rst_busy", bus.busy, 1'b0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.out_valid !== 1'b0) seen++;
      @(posedge clk); @(negedge clk);
    end
    check("mid_no_stale_valid", 32'(seen), 32'h0, 0);
    run_op(FXP_TWO, res, dbz, lat);
    check("post_rst_result", res, 32'h0000_8000, 1);
    check_bit("post_rst_dbz", dbz, 1'b0);
    check_lat("post_rst_lat", lat, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
